// File: rtl/alu_seq.sv
// alu_seq: multi-cycle sequential ALU with a start/done handshake and
// registered result and status flags.
//
// Ports:
//   clk           rising-edge clock
//   reset_n       asynchronous active-low reset
//   start_in      request, taken only while busy_out = 0
//   operation_in  operation select, sampled when the request is taken
//   A_in, B_in    operands, sampled when the request is taken
//   busy_out      operation in progress
//   done_out      one-cycle completion pulse
//   alu_out       registered result, held between completions
//   carry_out, zero_out, negative_out, overflow_out  registered flags
//   state_dbg     current FSM state (IDLE=0, EXEC=1, MUL=2)
//
// Handshake: a request is taken at a rising edge where start_in = 1 and the
// block is idle; busy_out is 1 from that edge until the completing edge, at
// which done_out rises for exactly one cycle. start_in seen while busy is
// dropped. A new request may be presented during the done_out cycle.
//
// Op encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MUL.
// Any value with bits above bit 2 set behaves as ADD.
module alu_seq #(
   parameter int DATA_WIDTH = 11,
   parameter int OP_WIDTH   = 3
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start_in,
   input  logic [OP_WIDTH-1:0]   operation_in,
   input  logic [DATA_WIDTH-1:0] A_in,
   input  logic [DATA_WIDTH-1:0] B_in,
   output logic                  busy_out,
   output logic                  done_out,
   output logic [DATA_WIDTH-1:0] alu_out,
   output logic                  carry_out,
   output logic                  zero_out,
   output logic                  negative_out,
   output logic                  overflow_out,
   output logic [1:0]            state_dbg
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, MUL = 2'd2} state_t;

   state_t               state_q, state_d;
   logic [OP_WIDTH-1:0]  op_q;
   logic [W-1:0]         a_q, b_q;
   logic [2*W-1:0]       acc_q, mcand_q;
   logic [W-1:0]         mplier_q;
   logic [CW-1:0]        count_q;

   logic                 accept, is_mul, mul_last;
   logic [W:0]           sum_add, sum_sub;
   logic [W-1:0]         shl_t, shr_t;
   logic                 shift_in_range;
   logic [W-1:0]         exec_res;
   logic                 exec_c, exec_v;
   logic [2*W-1:0]       mul_sum;

   assign state_dbg = state_q;
   assign accept    = (state_q == IDLE) && start_in;
   assign is_mul    = (operation_in == OP_WIDTH'(7));
   assign mul_last  = (count_q == CW'(W - 1));

   // FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_in) state_d = is_mul ? MUL : EXEC;
         EXEC:    state_d = IDLE;
         MUL:     if (mul_last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Single-cycle datapath on the latched operands
   always_comb begin
      sum_add  = {1'b0, a_q} + {1'b0, b_q};
      sum_sub  = {1'b0, a_q} + {1'b0, ~b_q} + (W+1)'(1);
      // Shifting by (B-1) leaves the last bit shifted out at the edge position
      shl_t    = a_q << (b_q - W'(1));
      shr_t    = a_q >> (b_q - W'(1));
      shift_in_range = (b_q != '0) && (b_q <= W'(W));
      exec_res = sum_add[W-1:0];
      exec_c   = sum_add[W];
      exec_v   = (a_q[W-1] == b_q[W-1]) && (sum_add[W-1] != a_q[W-1]);
      if ((op_q >> 3) == '0) begin
         case (op_q[2:0])
            3'd1: begin
               exec_res = sum_sub[W-1:0];
               exec_c   = sum_sub[W];
               exec_v   = (a_q[W-1] != b_q[W-1]) && (sum_sub[W-1] != a_q[W-1]);
            end
            3'd2: begin exec_res = a_q & b_q; exec_c = 1'b0; exec_v = 1'b0; end
            3'd3: begin exec_res = a_q | b_q; exec_c = 1'b0; exec_v = 1'b0; end
            3'd4: begin exec_res = a_q ^ b_q; exec_c = 1'b0; exec_v = 1'b0; end
            3'd5: begin
               exec_res = (b_q >= W'(W)) ? '0 : (a_q << b_q);
               exec_c   = shift_in_range ? shl_t[W-1] : 1'b0;
               exec_v   = 1'b0;
            end
            3'd6: begin
               exec_res = (b_q >= W'(W)) ? '0 : (a_q >> b_q);
               exec_c   = shift_in_range ? shr_t[0] : 1'b0;
               exec_v   = 1'b0;
            end
            default: ;
         endcase
      end
   end

   // One shift-add step: add the multiplicand when the current multiplier bit is set
   assign mul_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         acc_q        <= '0;
         mcand_q      <= '0;
         mplier_q     <= '0;
         count_q      <= '0;
         busy_out     <= 1'b0;
         done_out     <= 1'b0;
         alu_out      <= '0;
         carry_out    <= 1'b0;
         zero_out     <= 1'b0;
         negative_out <= 1'b0;
         overflow_out <= 1'b0;
      end else begin
         done_out <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  op_q     <= operation_in;
                  a_q      <= A_in;
                  b_q      <= B_in;
                  acc_q    <= '0;
                  mcand_q  <= {{W{1'b0}}, A_in};
                  mplier_q <= B_in;
                  count_q  <= '0;
                  busy_out <= 1'b1;
               end
            end
            EXEC: begin
               alu_out      <= exec_res;
               carry_out    <= exec_c;
               zero_out     <= (exec_res == '0);
               negative_out <= exec_res[W-1];
               overflow_out <= exec_v;
               done_out     <= 1'b1;
               busy_out     <= 1'b0;
            end
            MUL: begin
               acc_q    <= mul_sum;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               count_q  <= count_q + CW'(1);
               if (mul_last) begin
                  alu_out      <= mul_sum[W-1:0];
                  carry_out    <= (mul_sum[2*W-1:W] != '0);
                  zero_out     <= (mul_sum[W-1:0] == '0);
                  negative_out <= mul_sum[W-1];
                  overflow_out <= 1'b0;
                  done_out     <= 1'b1;
                  busy_out     <= 1'b0;
               end
            end
            default: busy_out <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed checks of alu_seq at the default width (11 bits).
// Inputs change on the falling edge or 1 ns after the rising edge; outputs
// are read 1 ns after the rising edge. Flags are compared as one vector
// {carry, zero, negative, overflow}.
module tb_alu_seq;

   logic        clk;
   logic        reset_n;
   logic        start_in;
   logic [2:0]  operation_in;
   logic [10:0] A_in, B_in;
   logic        busy_out, done_out;
   logic [10:0] alu_out;
   logic        carry_out, zero_out, negative_out, overflow_out;
   logic [1:0]  state_dbg;

   int errors = 0;
   int checks = 0;

   alu_seq #(.DATA_WIDTH(11), .OP_WIDTH(3)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start_in     (start_in),
      .operation_in (operation_in),
      .A_in         (A_in),
      .B_in         (B_in),
      .busy_out     (busy_out),
      .done_out     (done_out),
      .alu_out      (alu_out),
      .carry_out    (carry_out),
      .zero_out     (zero_out),
      .negative_out (negative_out),
      .overflow_out (overflow_out),
      .state_dbg    (state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive a request on the falling edge; returns 1 ns after the accepting edge.
   task automatic issue(input logic [2:0] op, input logic [10:0] a, input logic [10:0] b);
      @(negedge clk);
      start_in = 1'b1; operation_in = op; A_in = a; B_in = b;
      @(posedge clk); #1;
      start_in = 1'b0;
   endtask

   // Counts rising edges until done_out is seen; n = -1 if it never comes.
   task automatic wait_done(output int n);
      bit seen;
      seen = 1'b0;
      n = 0;
      while (!seen && n < 40) begin
         @(posedge clk); #1;
         n++;
         if (done_out) seen = 1'b1;
      end
      if (!seen) n = -1;
   endtask

   task automatic test_reset;
      reset_n = 1'b0; start_in = 1'b0; operation_in = '0; A_in = '0; B_in = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({busy_out, done_out, alu_out, carry_out, zero_out, negative_out, overflow_out} !== 17'd0) begin
         errors++;
         $display("FAIL reset_outputs: got busy=%b done=%b alu=%h flags=%b%b%b%b, want all 0",
                  busy_out, done_out, alu_out, carry_out, zero_out, negative_out, overflow_out);
      end
      checks++;
      if (state_dbg !== 2'd0) begin
         errors++; $display("FAIL reset_state: got %0d want 0", state_dbg);
      end
      @(negedge clk); reset_n = 1'b1;
   endtask

   task automatic test_add;
      issue(3'd0, 11'h3FF, 11'h001);
      checks++;
      if ({busy_out, done_out} !== 2'b10) begin
         errors++; $display("FAIL add_accept_busy: got busy,done=%b%b want 10", busy_out, done_out);
      end
      @(posedge clk); #1;
      checks++;
      if ({busy_out, done_out} !== 2'b01) begin
         errors++; $display("FAIL add_done_edge: got busy,done=%b%b want 01", busy_out, done_out);
      end
      checks++;
      if (alu_out !== 11'h400) begin
         errors++; $display("FAIL add_result: got %h want 400", alu_out);
      end
      checks++;
      if ({carry_out, zero_out, negative_out, overflow_out} !== 4'b0011) begin
         errors++; $display("FAIL add_flags: got %b want 0011",
                            {carry_out, zero_out, negative_out, overflow_out});
      end
      @(posedge clk); #1;
      checks++;
      if ({busy_out, done_out} !== 2'b00 || alu_out !== 11'h400) begin
         errors++; $display("FAIL add_hold: got busy,done=%b%b alu=%h want 00 400",
                            busy_out, done_out, alu_out);
      end
   endtask

   task automatic test_sub;
      logic [10:0] a_v [3] = '{11'h3FF, 11'h003, 11'h002};
      logic [10:0] b_v [3] = '{11'h002, 11'h003, 11'h003};
      logic [10:0] r_v [3] = '{11'h3FD, 11'h000, 11'h7FF};
      logic [3:0]  f_v [3] = '{4'b1000, 4'b1100, 4'b0010};
      int n;
      for (int i = 0; i < 3; i++) begin
         issue(3'd1, a_v[i], b_v[i]);
         wait_done(n);
         checks++;
         if (n !== 1 || alu_out !== r_v[i]) begin
            errors++; $display("FAIL sub_%0d_result: got %h after %0d edges want %h after 1",
                               i, alu_out, n, r_v[i]);
         end
         checks++;
         if ({carry_out, zero_out, negative_out, overflow_out} !== f_v[i]) begin
            errors++; $display("FAIL sub_%0d_flags: got %b want %b", i,
                               {carry_out, zero_out, negative_out, overflow_out}, f_v[i]);
         end
      end
   endtask

   task automatic test_logic;
      int n;
      issue(3'd2, 11'h5A5, 11'h0FF);
      wait_done(n);
      checks++;
      if (alu_out !== 11'h0A5 || {carry_out, zero_out, negative_out, overflow_out} !== 4'b0000) begin
         errors++; $display("FAIL and_result: got %h flags %b want 0a5 0000", alu_out,
                            {carry_out, zero_out, negative_out, overflow_out});
      end
      issue(3'd3, 11'h400, 11'h001);
      wait_done(n);
      checks++;
      if (alu_out !== 11'h401 || {carry_out, zero_out, negative_out, overflow_out} !== 4'b0010) begin
         errors++; $display("FAIL or_result: got %h flags %b want 401 0010", alu_out,
                            {carry_out, zero_out, negative_out, overflow_out});
      end
   endtask

   task automatic test_mul;
      int n;
      issue(3'd7, 11'h01F, 11'h021);
      wait_done(n);
      checks++;
      if (n !== 11) begin
         errors++; $display("FAIL mul_latency: got %0d edges want 11", n);
      end
      checks++;
      if (alu_out !== 11'h3FF || {carry_out, zero_out, negative_out, overflow_out} !== 4'b0000) begin
         errors++; $display("FAIL mul_1f_21: got %h flags %b want 3ff 0000", alu_out,
                            {carry_out, zero_out, negative_out, overflow_out});
      end
      issue(3'd7, 11'h040, 11'h040);
      wait_done(n);
      checks++;
      if (n !== 11 || alu_out !== 11'h000 || {carry_out, zero_out, negative_out, overflow_out} !== 4'b1100) begin
         errors++; $display("FAIL mul_40_40: got %h flags %b after %0d edges want 000 1100 after 11",
                            alu_out, {carry_out, zero_out, negative_out, overflow_out}, n);
      end
   endtask

   task automatic test_shift;
      int n;
      issue(3'd5, 11'h401, 11'd1);
      wait_done(n);
      checks++;
      if (alu_out !== 11'h002 || {carry_out, zero_out, negative_out, overflow_out} !== 4'b1000) begin
         errors++; $display("FAIL shl_401_1: got %h flags %b want 002 1000", alu_out,
                            {carry_out, zero_out, negative_out, overflow_out});
      end
      issue(3'd6, 11'h003, 11'd11);
      wait_done(n);
      checks++;
      if (alu_out !== 11'h000 || {carry_out, zero_out, negative_out, overflow_out} !== 4'b0100) begin
         errors++; $display("FAIL shr_003_11: got %h flags %b want 000 0100", alu_out,
                            {carry_out, zero_out, negative_out, overflow_out});
      end
   endtask

   // MUL with stray start pulses, then an XOR presented in the done cycle.
   task automatic test_back_to_back;
      int dones;
      int n;
      dones = 0;
      issue(3'd7, 11'h01F, 11'h021);
      for (n = 1; n <= 11; n++) begin
         @(posedge clk); #1;
         if (done_out) dones++;
         if (n == 2 || n == 4) begin
            start_in = 1'b1; operation_in = 3'd0; A_in = 11'h001; B_in = 11'h001;
         end else if (n == 11) begin
            start_in = 1'b1; operation_in = 3'd4; A_in = 11'h155; B_in = 11'h0FF;
         end else begin
            start_in = 1'b0;
         end
      end
      checks++;
      if (dones !== 1 || alu_out !== 11'h3FF || carry_out !== 1'b0) begin
         errors++; $display("FAIL busy_ignore: got %0d dones alu=%h carry=%b want 1 3ff 0",
                            dones, alu_out, carry_out);
      end
      @(posedge clk); #1;
      start_in = 1'b0;
      checks++;
      if ({busy_out, done_out} !== 2'b10) begin
         errors++; $display("FAIL b2b_accept: got busy,done=%b%b want 10", busy_out, done_out);
      end
      @(posedge clk); #1;
      checks++;
      if (done_out !== 1'b1 || alu_out !== 11'h1AA ||
          {carry_out, zero_out, negative_out, overflow_out} !== 4'b0000) begin
         errors++; $display("FAIL b2b_xor: got done=%b alu=%h flags %b want 1 1aa 0000", done_out,
                            alu_out, {carry_out, zero_out, negative_out, overflow_out});
      end
   endtask

   task automatic test_async_reset;
      int dones;
      int n;
      dones = 0;
      issue(3'd7, 11'h01F, 11'h021);
      repeat (4) @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({busy_out, done_out, alu_out, carry_out, zero_out, negative_out, overflow_out} !== 17'd0
          || state_dbg !== 2'd0) begin
         errors++; $display("FAIL async_reset: got busy=%b done=%b alu=%h state=%0d want all 0",
                            busy_out, done_out, alu_out, state_dbg);
      end
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (done_out) dones++;
         if (i == 2) reset_n = 1'b1;
      end
      checks++;
      if (dones !== 0 || alu_out !== 11'h000) begin
         errors++; $display("FAIL reset_discard: got %0d dones alu=%h want 0 000", dones, alu_out);
      end
      issue(3'd0, 11'h001, 11'h001);
      wait_done(n);
      checks++;
      if (n !== 1 || alu_out !== 11'h002) begin
         errors++; $display("FAIL post_reset_add: got %h after %0d edges want 002 after 1", alu_out, n);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_logic();
      test_mul();
      test_shift();
      test_back_to_back();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
